cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 18 +
 rtl/cdb_result_fifo.sv | 57 +++++
 rtl/cdb_arbiter.sv | 87 ++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus result path: widths, source identity and
// the buffered result entry.
package cdb_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } result_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-source result buffer: DEPTH-entry circular FIFO with registered-count ready.
module cdb_result_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output result_t pop_data,
  output logic    ready,
  output logic    not_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  result_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign ready     = (count < FULL_CNT);
  assign not_empty = (count != '0);
  assign do_wr     = push && ready;
  assign do_rd     = pop && not_empty;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only read after its write, and the count gates validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers adder/multiplier results and broadcasts one per
// cycle with a round-robin pointer between the two sources.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_result_valid,
  input  logic [TAG_W-1:0]  add_result_tag,
  input  logic [DATA_W-1:0] add_result_value,
  output logic              add_result_ready,
  input  logic              mul_result_valid,
  input  logic [TAG_W-1:0]  mul_result_tag,
  input  logic [DATA_W-1:0] mul_result_value,
  output logic              mul_result_ready,
  output logic              bus_valid_output,
  output logic [TAG_W-1:0]  broadcasted_tag,
  output logic [DATA_W-1:0] broadcasted_value,
  output logic              tag_error
);

  result_t add_in, mul_in, add_head, mul_head, grant_data;
  logic    add_push, mul_push, add_ne, mul_ne;
  logic    grant_valid, pop_add, pop_mul;
  src_e    prio, winner;

  assign add_in   = '{tag: add_result_tag, value: add_result_value};
  assign mul_in   = '{tag: mul_result_tag, value: mul_result_value};
  assign add_push = add_result_valid && add_result_ready;
  assign mul_push = mul_result_valid && mul_result_ready;

  cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_add_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (add_push),
    .push_data (add_in),
    .pop       (pop_add),
    .pop_data  (add_head),
    .ready     (add_result_ready),
    .not_empty (add_ne)
  );

  cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_mul_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mul_push),
    .push_data (mul_in),
    .pop       (pop_mul),
    .pop_data  (mul_head),
    .ready     (mul_result_ready),
    .not_empty (mul_ne)
  );

  // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    grant_valid = add_ne || mul_ne;
    winner      = SRC_ADD;
    if (add_ne && mul_ne) winner = prio;
    else if (mul_ne)      winner = SRC_MUL;
    pop_add    = grant_valid && (winner == SRC_ADD);
    pop_mul    = grant_valid && (winner == SRC_MUL);
    grant_data = (winner == SRC_MUL) ? mul_head : add_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio              <= SRC_ADD;
      bus_valid_output  <= 1'b0;
      broadcasted_tag   <= '0;
      broadcasted_value <= '0;
      tag_error         <= 1'b0;
    end else begin
      bus_valid_output <= grant_valid;
      if (grant_valid) begin
        broadcasted_tag   <= grant_data.tag;
        broadcasted_value <= grant_data.value;
        prio              <= (winner == SRC_ADD) ? SRC_MUL : SRC_ADD;
      end
      // Mis-tagged results are still forwarded; the flag only records that it happened.
      if ((add_push && add_result_tag[TAG_W-1]) || (mul_push && !mul_result_tag[TAG_W-1]))
        tag_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              add_result_valid = 1'b0;
  logic [TAG_W-1:0]  add_result_tag = '0;
  logic [DATA_W-1:0] add_result_value = '0;
  logic              add_result_ready;
  logic              mul_result_valid = 1'b0;
  logic [TAG_W-1:0]  mul_result_tag = '0;
  logic [DATA_W-1:0] mul_result_value = '0;
  logic              mul_result_ready;
  logic              bus_valid_output;
  logic [TAG_W-1:0]  broadcasted_tag;
  logic [DATA_W-1:0] broadcasted_value;
  logic              tag_error;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .add_result_valid  (add_result_valid),
    .add_result_tag    (add_result_tag),
    .add_result_value  (add_result_value),
    .add_result_ready  (add_result_ready),
    .mul_result_valid  (mul_result_valid),
    .mul_result_tag    (mul_result_tag),
    .mul_result_value  (mul_result_value),
    .mul_result_ready  (mul_result_ready),
    .bus_valid_output  (bus_valid_output),
    .broadcasted_tag   (broadcasted_tag),
    .broadcasted_value (broadcasted_value),
    .tag_error         (tag_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per source plus a "who goes next on a tie" bit.
  result_t     qa[$];
  result_t     qm[$];
  bit          m_mul_next;
  bit          m_bv;
  logic [2:0]  m_tag;
  logic [31:0] m_val;
  bit          m_te;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit av, input logic [2:0] at, input logic [31:0] ad,
                       input bit mv, input logic [2:0] mt, input logic [31:0] md);
    rst = r;
    add_result_valid = av; add_result_tag = at; add_result_value = ad;
    mul_result_valid = mv; mul_result_tag = mt; mul_result_value = md;
  endtask

  task automatic model_update();
    bit acc_a, acc_m, take_mul;
    result_t e;
    if (rst) begin
      qa.delete(); qm.delete();
      m_mul_next = 0; m_bv = 0; m_tag = '0; m_val = '0; m_te = 0;
      return;
    end
    acc_a = add_result_valid && (qa.size() < DEPTH);
    acc_m = mul_result_valid && (qm.size() < DEPTH);
    m_bv = 0;
    if (qa.size() > 0 || qm.size() > 0) begin
      take_mul = (qa.size() == 0) || (qm.size() > 0 && m_mul_next);
      e = take_mul ? qm.pop_front() : qa.pop_front();
      m_bv = 1; m_tag = e.tag; m_val = e.value;
      m_mul_next = !take_mul;
    end
    if (acc_a) begin
      qa.push_back('{tag: add_result_tag, value: add_result_value});
      if (add_result_tag[2]) m_te = 1;
    end
    if (acc_m) begin
      qm.push_back('{tag: mul_result_tag, value: mul_result_value});
      if (!mul_result_tag[2]) m_te = 1;
    end
  endtask

  // One clock with model comparison: readies before the edge, outputs just after it.
  task automatic step(input string name);
    check({name, "_add_ready"}, add_result_ready, qa.size() < DEPTH);
    check({name, "_mul_ready"}, mul_result_ready, qm.size() < DEPTH);
    @(posedge clk);
    model_update();
    #1;
    check({name, "_bv"}, bus_valid_output, m_bv);
    check({name, "_tag_error"}, tag_error, m_te);
    if (m_bv) begin
      check({name, "_tag"}, broadcasted_tag, m_tag);
      check({name, "_value"}, broadcasted_value, m_val);
    end
  endtask

  typedef struct {
    bit          r;
    bit          av;
    logic [2:0]  at;
    logic [31:0] ad;
    bit          mv;
    logic [2:0]  mt;
    logic [31:0] md;
    bit          e_bv;
    logic [2:0]  e_tag;
    logic [31:0] e_val;
    bit          e_ar;
    bit          e_mr;
    bit          e_te;
  } vec_t;

  vec_t vecs[$];

  initial begin
    //          r  av at      ad  mv mt      md  bv tag     val ar mr te
    vecs.push_back('{1, 0, 3'b000, 0,  0, 3'b000, 0,  0, 3'b000, 0,  1, 1, 0});
    vecs.push_back('{0, 1, 3'b001, 5,  0, 3'b000, 0,  0, 3'b000, 0,  1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b001, 5,  1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  0, 3'b001, 5,  1, 1, 0});
    vecs.push_back('{1, 0, 3'b000, 0,  0, 3'b000, 0,  0, 3'b000, 0,  1, 1, 0});
    vecs.push_back('{0, 1, 3'b000, 10, 1, 3'b100, 20, 0, 3'b000, 0,  1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b000, 10, 1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b100, 20, 1, 1, 0});
    vecs.push_back('{0, 1, 3'b010, 8,  1, 3'b101, 7,  0, 3'b100, 20, 1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b010, 8,  1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b101, 7,  1, 1, 0});
    vecs.push_back('{0, 1, 3'b110, 3,  0, 3'b000, 0,  0, 3'b101, 7,  1, 1, 1});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b110, 3,  1, 1, 1});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  0, 3'b110, 3,  1, 1, 1});
    vecs.push_back('{1, 0, 3'b000, 0,  0, 3'b000, 0,  0, 3'b000, 0,  1, 1, 0});
    vecs.push_back('{0, 0, 3'b000, 0,  1, 3'b011, 9,  0, 3'b000, 0,  1, 1, 1});
    vecs.push_back('{0, 0, 3'b000, 0,  0, 3'b000, 0,  1, 3'b011, 9,  1, 1, 1});

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].av, vecs[i].at, vecs[i].ad, vecs[i].mv, vecs[i].mt, vecs[i].md);
      @(posedge clk);
      model_update();
      #1;
      check($sformatf("vec%0d_bv", i),    bus_valid_output,  vecs[i].e_bv);
      check($sformatf("vec%0d_tag", i),   broadcasted_tag,   vecs[i].e_tag);
      check($sformatf("vec%0d_value", i), broadcasted_value, vecs[i].e_val);
      check($sformatf("vec%0d_ar", i),    add_result_ready,  vecs[i].e_ar);
      check($sformatf("vec%0d_mr", i),    mul_result_ready,  vecs[i].e_mr);
      check($sformatf("vec%0d_te", i),    tag_error,         vecs[i].e_te);
    end

    // Fairness: adder always offering, multiplier offering three results.
    begin
      int mul_sent = 0;
      bit seen[$];
      drive(1, 0, 0, 0, 0, 0, 0); step("rr_rst");
      for (int c = 0; c < 12; c++) begin
        drive(0, 1, 3'(c % 4), 32'(100 + c), mul_sent < 3, 3'(4 + mul_sent), 32'(200 + mul_sent));
        if (mul_sent < 3 && qm.size() < DEPTH) mul_sent++;
        step("rr");
        if (bus_valid_output && seen.size() < 6) seen.push_back(broadcasted_tag[2]);
      end
      check("rr_count", seen.size(), 6);
      for (int k = 0; k < 6 && k < seen.size(); k++)
        check($sformatf("rr_src%0d", k), seen[k], k % 2);
    end

    // Backpressure with DEPTH=2: adder fills while the pointer favours the multiplier.
    begin
      int guard = 0;
      drive(1, 0, 0, 0, 0, 0, 0);              step("bp_rst");
      drive(0, 1, 3'b000, 1, 0, 0, 0);         step("bp_pre");
      drive(0, 0, 0, 0, 0, 0, 0);              step("bp_pre2");
      drive(0, 1, 3'b001, 100, 1, 3'b101, 200); step("bp_a1");
      drive(0, 1, 3'b010, 101, 0, 0, 0);       step("bp_a2");
      check("bp_ready_low", add_result_ready, 0);
      drive(0, 1, 3'b011, 102, 0, 0, 0);
      while (qa.size() >= DEPTH && guard < 10) begin
        step("bp_hold");
        guard++;
      end
      check("bp_hold_bound", guard < 10, 1);
      step("bp_a3");
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) step("bp_drain");
      check("bp_last_tag", broadcasted_tag, 3'b011);
      check("bp_last_value", broadcasted_value, 102);
    end

    // Reset with both buffers holding entries.
    begin
      drive(1, 0, 0, 0, 0, 0, 0);            step("rs_rst");
      drive(0, 1, 3'b001, 11, 1, 3'b110, 22); step("rs_fill1");
      drive(0, 1, 3'b010, 12, 1, 3'b111, 23); step("rs_fill2");
      drive(0, 1, 3'b011, 13, 1, 3'b100, 24); step("rs_fill3");
      drive(1, 1, 3'b000, 14, 1, 3'b101, 25); step("rs_assert");
      check("rs_tag", broadcasted_tag, 0);
      check("rs_value", broadcasted_value, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      check("rs_add_ready", add_result_ready, 1);
      check("rs_mul_ready", mul_result_ready, 1);
      for (int c = 0; c < 4; c++) begin
        step("rs_idle");
        check("rs_no_bcast", bus_valid_output, 0);
      end
    end

    // Randomized traffic, including occasional bad tags and resets.
    for (int c = 0; c < 400; c++) begin
      bit          r  = ($urandom_range(0, 49) == 0);
      bit          av = $urandom_range(0, 1);
      bit          mv = $urandom_range(0, 1);
      logic [2:0]  at = {($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3))};
      logic [2:0]  mt = {($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3))};
      drive(r, av, at, $urandom, mv, mt, $urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
